// File: rtl/ibuf.sv
// Instruction buffer: queues 128-bit fetch lines and issues their 32-bit slots to decode
// one per cycle, starting at each line's select slot.
`ifndef ANOM_PC_WIDTH
`define ANOM_PC_WIDTH 30
`endif

module ibuf #(
  parameter int unsigned PC_WIDTH = `ANOM_PC_WIDTH,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                      i_Clk,
  input  logic                      i_RstN,
  input  logic                      i_LineV,
  input  logic [127:0]              i_LineD,
  input  logic [PC_WIDTH-3:0]       i_LineA,
  input  logic [1:0]                i_LineSel,
  output logic                      o_LineR,
  input  logic                      i_Flush,
  output logic                      o_InstrV,
  output logic [31:0]               o_Instr,
  output logic [PC_WIDTH-1:0]       o_InstrPC,
  input  logic                      i_InstrR,
  output logic [$clog2(DEPTH):0]    o_Count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned AddrW = PC_WIDTH - 2;
  localparam logic [PtrW:0] CountFull = DEPTH[PtrW:0];
  localparam logic [PtrW:0] CountOne = 1;
  localparam logic [PtrW-1:0] PtrOne = 1;

  logic [127:0]     dataMem [DEPTH];
  logic [AddrW-1:0] addrMem [DEPTH];
  logic [1:0]       slotMem [DEPTH];

  logic [PtrW-1:0] wrPtr, rdPtr;
  logic [PtrW:0]   count;
  logic            push, consume, pop;
  logic [1:0]      headSlot;
  logic [127:0]    headData;

  assign o_Count  = count;
  assign o_LineR  = (count != CountFull);
  assign o_InstrV = (count != '0);
  assign headSlot = slotMem[rdPtr];
  assign headData = dataMem[rdPtr];

  assign push    = i_LineV & o_LineR & ~i_Flush;
  assign consume = o_InstrV & i_InstrR & ~i_Flush;
  assign pop     = consume & (headSlot == 2'd3);

  always_comb begin
    o_Instr   = '0;
    o_InstrPC = '0;
    if (o_InstrV) begin
      unique case (headSlot)
        2'd0:    o_Instr = headData[31:0];
        2'd1:    o_Instr = headData[63:32];
        2'd2:    o_Instr = headData[95:64];
        default: o_Instr = headData[127:96];
      endcase
      o_InstrPC = {addrMem[rdPtr], headSlot};
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_RstN || i_Flush) begin
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PtrOne;
      if (pop)  rdPtr <= rdPtr + PtrOne;
      if (push && !pop)      count <= count + CountOne;
      else if (pop && !push) count <= count - CountOne;
    end
  end

  // Entry payload is never cleared; occupancy alone says what is live.
  // A push never targets the head entry while it is being consumed (that would need a full buffer).
  always_ff @(posedge i_Clk) begin
    if (i_RstN) begin
      if (push) begin
        dataMem[wrPtr] <= i_LineD;
        addrMem[wrPtr] <= i_LineA;
        slotMem[wrPtr] <= i_LineSel;
      end
      if (consume && !pop) slotMem[rdPtr] <= headSlot + 2'd1;
    end
  end

endmodule

// File: tb/tb_ibuf.sv
// Self-checking bench for ibuf: directed scenarios plus randomized traffic against a
// queue-of-lines reference model.
module tb_ibuf;

  localparam int PcW = 30;
  localparam int Depth = 4;

  typedef struct {
    logic [127:0]   d;
    logic [PcW-3:0] a;
    logic [1:0]     s;
  } line_t;

  logic            clk = 1'b0;
  logic            rstN, lineV, flush, instrR;
  logic [127:0]    lineD;
  logic [PcW-3:0]  lineA;
  logic [1:0]      lineSel;
  logic            lineR, instrV;
  logic [31:0]     instr;
  logic [PcW-1:0]  instrPC;
  logic [2:0]      count;

  int nChecks = 0;
  int nErrors = 0;
  line_t mq[$];

  always #5 clk = ~clk;

  ibuf #(.PC_WIDTH(PcW), .DEPTH(Depth)) dut (
    .i_Clk(clk), .i_RstN(rstN), .i_LineV(lineV), .i_LineD(lineD), .i_LineA(lineA),
    .i_LineSel(lineSel), .o_LineR(lineR), .i_Flush(flush), .o_InstrV(instrV),
    .o_Instr(instr), .o_InstrPC(instrPC), .i_InstrR(instrR), .o_Count(count)
  );

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs derived from the queue of pending lines.
  task automatic checkModel();
    logic [127:0]   sh;
    logic [31:0]    expI;
    logic [PcW-1:0] expPc;
    expI = '0;
    expPc = '0;
    if (mq.size() != 0) begin
      sh = mq[0].d >> (32 * int'(mq[0].s));
      expI = sh[31:0];
      expPc = {mq[0].a, mq[0].s};
    end
    checkEq("m_instrV", 64'(instrV), 64'(mq.size() != 0));
    checkEq("m_lineR", 64'(lineR), 64'(mq.size() != Depth));
    checkEq("m_count", 64'(count), 64'(mq.size()));
    checkEq("m_instr", 64'(instr), 64'(expI));
    checkEq("m_pc", 64'(instrPC), 64'(expPc));
  endtask

  task automatic modelEdge();
    line_t n;
    logic doConsume, doPush;
    if (!rstN || flush) begin
      mq.delete();
    end else begin
      doConsume = (mq.size() != 0) && instrR;
      doPush = lineV && (mq.size() != Depth);
      if (doConsume) begin
        if (mq[0].s == 2'd3) void'(mq.pop_front());
        else mq[0].s = mq[0].s + 2'd1;
      end
      if (doPush) begin
        n.d = lineD;
        n.a = lineA;
        n.s = lineSel;
        mq.push_back(n);
      end
    end
  endtask

  // Called at a falling edge with inputs set: check, clock, advance model.
  task automatic cyc();
    checkModel();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic setLine(input logic [127:0] d, input logic [PcW-3:0] a, input logic [1:0] s);
    lineV = 1'b1;
    lineD = d;
    lineA = a;
    lineSel = s;
  endtask

  function automatic logic [127:0] rndLine();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] BasicLine = 128'h44444444_33333333_22222222_11111111;

  initial begin
    logic [127:0] firstD;
    rstN = 1'b0; lineV = 1'b0; flush = 1'b0; instrR = 1'b0;
    lineD = '0; lineA = '0; lineSel = '0;
    @(negedge clk);
    cyc();
    cyc();
    rstN = 1'b1;
    checkEq("rst_instrV", 64'(instrV), 64'd0);
    checkEq("rst_lineR", 64'(lineR), 64'd1);
    checkEq("rst_count", 64'(count), 64'd0);

    // Basic four-slot line
    instrR = 1'b1;
    setLine(BasicLine, 28'h0000010, 2'd0);
    cyc();
    lineV = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkEq("basic_instr", 64'(instr), 64'(32'h11111111 * (k + 1)));
      checkEq("basic_pc", 64'(instrPC), 64'(32'h40 + k));
      cyc();
    end
    checkEq("basic_drain", 64'(instrV), 64'd0);

    // Slot skip
    setLine(BasicLine, 28'h0000010, 2'd2);
    cyc();
    lineV = 1'b0;
    checkEq("skip_instr2", 64'(instr), 64'h33333333);
    checkEq("skip_pc2", 64'(instrPC), 64'h42);
    cyc();
    checkEq("skip_instr3", 64'(instr), 64'h44444444);
    checkEq("skip_pc3", 64'(instrPC), 64'h43);
    cyc();
    checkEq("skip_empty", 64'(instrV), 64'd0);
    setLine(BasicLine, 28'h0000010, 2'd3);
    cyc();
    lineV = 1'b0;
    checkEq("sel3_instr", 64'(instr), 64'h44444444);
    cyc();
    checkEq("sel3_once", 64'(instrV), 64'd0);

    // Full / backpressure
    instrR = 1'b0;
    firstD = rndLine();
    for (int i = 0; i < 5; i++) begin
      setLine((i == 0) ? firstD : rndLine(), 28'(32'h100 + i), 2'd3);
      if (i == 4) checkEq("full_lineR", 64'(lineR), 64'd0);
      cyc();
    end
    lineV = 1'b0;
    checkEq("full_count", 64'(count), 64'd4);
    checkEq("full_hold", 64'(instr), 64'(firstD[127:96]));
    cyc();
    checkEq("full_hold2", 64'(instr), 64'(firstD[127:96]));
    instrR = 1'b1;
    checkEq("pop_lineR0", 64'(lineR), 64'd0);
    cyc();
    checkEq("pop_lineR1", 64'(lineR), 64'd1);
    for (int i = 0; i < 6; i++) cyc();
    checkEq("full_drained", 64'(instrV), 64'd0);

    // Concurrent push with slot-3 pop; entries straddle the pointer wrap
    instrR = 1'b0;
    setLine(rndLine(), 28'h200, 2'd2);
    cyc();
    setLine(rndLine(), 28'h201, 2'd0);
    cyc();
    lineV = 1'b0;
    instrR = 1'b1;
    cyc();
    setLine(rndLine(), 28'h202, 2'd1);
    cyc();
    lineV = 1'b0;
    checkEq("concur_count", 64'(count), 64'd2);
    for (int i = 0; i < 10; i++) cyc();

    // Flush with simultaneous push and consume
    instrR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setLine(rndLine(), 28'(32'h300 + i), 2'd0);
      cyc();
    end
    flush = 1'b1;
    instrR = 1'b1;
    setLine(rndLine(), 28'h3ff, 2'd0);
    cyc();
    flush = 1'b0;
    checkEq("flush_count", 64'(count), 64'd0);
    checkEq("flush_instrV", 64'(instrV), 64'd0);
    checkEq("flush_lineR", 64'(lineR), 64'd1);
    setLine(BasicLine, 28'h0000020, 2'd1);
    cyc();
    lineV = 1'b0;
    checkEq("postflush_instr", 64'(instr), 64'h22222222);
    checkEq("postflush_pc", 64'(instrPC), 64'h81);
    for (int i = 0; i < 4; i++) cyc();

    // Reset mid-stream with head at slot 2
    instrR = 1'b0;
    setLine(rndLine(), 28'h400, 2'd2);
    cyc();
    setLine(rndLine(), 28'h401, 2'd0);
    cyc();
    lineV = 1'b0;
    rstN = 1'b0;
    cyc();
    rstN = 1'b1;
    checkEq("mrst_count", 64'(count), 64'd0);
    checkEq("mrst_instr", 64'(instr), 64'd0);
    checkEq("mrst_pc", 64'(instrPC), 64'd0);
    instrR = 1'b1;
    setLine(BasicLine, 28'h0000030, 2'd0);
    cyc();
    lineV = 1'b0;
    checkEq("mrst_resume", 64'(instr), 64'h11111111);
    for (int i = 0; i < 4; i++) cyc();

    // Randomized traffic with shifting ready bias
    for (int i = 0; i < 3000; i++) begin
      int rdyPct;
      rdyPct = ((i / 200) % 3 == 0) ? 20 : (((i / 200) % 3 == 1) ? 90 : 55);
      rstN = ($urandom_range(0, 299) != 0);
      flush = ($urandom_range(0, 39) == 0);
      instrR = ($urandom_range(0, 99) < rdyPct);
      lineV = ($urandom_range(0, 99) < 60);
      lineD = rndLine();
      lineA = 28'($urandom);
      lineSel = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/ibuf.md
# ibuf

Instruction buffer between the instruction fetch unit and the decoder. It accepts 128-bit fetch lines (four 32-bit instructions) together with the fetch unit's 2-bit start-slot select. It queues up to DEPTH lines and hands instructions to decode one per cycle over a valid/ready handshake, skipping the slots the select marks as dropped. A flush input discards all buffered and in-flight state on a jump.

## Interface
- PC_WIDTH, default `ANOM_PC_WIDTH (30): word-address PC width; line address is PC_WIDTH-2 bits.
- DEPTH, default 4: number of line entries; power of two, ≥2.

- i_Clk  input  1  core clock; all state updates on its rising edge.
- i_RstN  input  1  reset, synchronous, active-low.
- i_LineV  input  1  fetch line valid.
- i_LineD  input  128  fetch line data; slot k occupies bits [32k+31:32k].
- i_LineA  input  PC_WIDTH-2  line address.
- i_LineSel  input  2  first valid slot of the line; slots below it are dropped.
- o_LineR  output  1  line ready; a line is accepted when i_LineV & o_LineR.
- i_Flush  input  1  discard all buffered lines; highest priority.
- o_InstrV  output  1  instruction valid to decode.
- o_Instr  output  32  instruction word.
- o_InstrPC  output  PC_WIDTH  instruction word address = {line address, slot}.
- i_InstrR  input  1  decode ready; an instruction is consumed when o_InstrV & i_InstrR.
- o_Count  output  log2(DEPTH)+1  number of occupied line entries.

## Operation
- Storage: DEPTH entries, each holding {data[127:0], addr, slot[1:0]}. Write pointer, read pointer and count are registered. Pointers are log2(DEPTH) bits and wrap naturally.
- Push: when i_LineV & o_LineR & ~i_Flush, the line is written at the write pointer, slot = i_LineSel, and the write pointer increments.
- o_LineR = (count != DEPTH), decoded from the registered count only. No same-cycle pop bypass: a full buffer refuses the line even if a pop occurs that cycle.
- Head: o_InstrV = (count != 0).
- o_Instr = head.data[32*head.slot +: 32].
- o_InstrPC = {head.addr, head.slot}.
- When o_InstrV = 0, o_Instr and o_InstrPC are driven to 0.
- Consume (o_InstrV & i_InstrR & ~i_Flush):
  - head.slot != 3: head.slot increments; the line stays.
  - head.slot == 3: pop; the read pointer increments. The next entry presents its own stored slot.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged
  - neither: unchanged
- Flush: on the next edge, count = 0 and both pointers = 0. Any push or consume in the flush cycle is ignored. Entry data is not cleared.
- Reset (i_RstN = 0 at an edge): count = 0 and pointers = 0, so o_InstrV = 0, o_LineR = 1, o_Count = 0, and o_Instr and o_InstrPC read 0. Reset overrides flush, push and consume. Reset mid-stream discards all contents.

## Timing
- Line accepted at edge N is visible on o_InstrV/o_Instr from cycle N+1 (one-cycle latency) when the buffer was empty.
- Throughput: one instruction per cycle while i_InstrR = 1 and lines are available. A line with i_LineSel = s yields 4-s instructions over 4-s consecutive cycles.
- o_InstrV, o_Instr and o_InstrPC are functions of registered state only; there is no combinational path from i_InstrR, i_LineV or i_Flush to any output.
- o_LineR depends only on registered count.
- After flush at edge N: o_InstrV = 0 and o_LineR = 1 in cycle N+1. A line presented in cycle N+1 is accepted.
- Full and pop in the same cycle: o_LineR = 0 that cycle; o_LineR = 1 the cycle after.
- o_InstrV stays high and o_Instr stays stable while i_InstrR = 0.

## Test plan
- Reset/basic:
  - Hold i_RstN = 0 for 2 cycles, then release. Expect o_InstrV = 0, o_LineR = 1, o_Count = 0.
  - Push D = {0x44444444, 0x33333333, 0x22222222, 0x11111111}, A = 0x0000010, Sel = 0, with i_InstrR = 1. Expect 0x11111111..0x44444444 on four consecutive cycles starting 1 cycle after the push, PCs 0x40..0x43, then o_InstrV = 0.
- Slot skip:
  - Push the same line with Sel = 2. Expect only 0x33333333 (PC 0x42) and then 0x44444444 (PC 0x43).
  - Then push a Sel = 3 line. Expect exactly one instruction from it.
- Full/backpressure:
  - With i_InstrR = 0, push 5 lines back-to-back. Expect 4 accepted, o_Count = 4, o_LineR = 0 on the 5th, and o_Instr held stable.
  - Raise i_InstrR. Expect o_LineR to return to 1 one cycle after the first pop.
- Concurrent push/pop: with o_Count = 2, push a line in the same cycle as the slot-3 consume of the head. Expect o_Count to remain 2, and pointer wrap across entry DEPTH-1 → 0 to be correct.
- Flush:
  - With 3 lines buffered, assert i_Flush together with i_LineV and i_InstrR. Expect the next cycle o_Count = 0 and o_InstrV = 0, the flush-cycle line not stored, and the consume ignored.
  - A post-flush line with Sel = 1 appears one cycle later at slot 1.
- Reset mid-operation: with 2 lines buffered and the head at slot 2, assert i_RstN = 0 for one edge. Expect an empty buffer, o_Instr = 0, and normal operation on the next push.
